svc_rv_mem_model: RTL and testbench

Parametrised memory timing and stall model for formal and simulation harnesses of the `svc_rv` core. One instance models one memory port (instruction or data). It covers:
- configurable read latency, 0 to 4 cycles, SRAM-like or BRAM-like;
- bounded, solver-chosen stall injection;
- read-data hold while stalled.

The harness owns the data source, either an immutable word array or an unconstrained value. This block produces the lookup index, the registered read data and the `dmem_stall`-style stall signal for the core.

---
 rtl/svc_rv_mem_model.sv | 66 ++++++
 tb/tb_svc_rv_mem_model.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/svc_rv_mem_model.sv
// svc_rv_mem_model: memory port read-latency and bounded-stall model for svc_rv harnesses
// Stall injection is built only when SVC_RV_MEM_MODEL_STALL_EN is defined.
module svc_rv_mem_model #(
  parameter int DW = 32,
  parameter int WORDS = 32,
  parameter int IDX_W = $clog2(WORDS),
  parameter int LATENCY = 1,
  parameter int MAX_STALL = 2,
  parameter logic [DW-1:0] RESET_RDATA = 32'h00000013
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_ren,
  input  logic [31:0]      req_raddr,
  output logic [IDX_W-1:0] src_idx,
  input  logic [DW-1:0]    src_rdata,
  input  logic             stall_req,
  output logic             stall,
  output logic [DW-1:0]    rdata,
  output logic             rvalid,
  output logic [2:0]       stall_cnt
);
  logic unused;
  assign src_idx = req_raddr[IDX_W+1:2];
`ifdef SVC_RV_MEM_MODEL_STALL_EN
  logic pending;
  assign unused = ^{req_raddr[31:IDX_W+2], req_raddr[1:0]};
  assign stall = stall_req && pending && (stall_cnt < 3'(MAX_STALL));
  // stall only fires below MAX_STALL, so the increment saturates on its own
  always_ff @(posedge clock)
    if (reset) begin
      pending <= 1'b0;
      stall_cnt <= 3'd0;
    end else begin
      pending <= req_ren || stall;
      stall_cnt <= stall ? stall_cnt + 3'd1 : 3'd0;
    end
`else
  assign unused = ^{req_raddr[31:IDX_W+2], req_raddr[1:0], stall_req};
  assign stall = 1'b0;
  assign stall_cnt = 3'd0;
`endif
  generate
    if (LATENCY == 0) begin : g_comb
      assign rdata = req_ren ? src_rdata : '0;
      assign rvalid = req_ren;
    end else begin : g_pipe
      logic [LATENCY:1] v;
      logic [DW-1:0]    d [1:LATENCY];
      always_ff @(posedge clock)
        if (reset) begin
          v <= '0;
          for (int k = 1; k <= LATENCY; k++) d[k] <= RESET_RDATA;
        end else if (!stall) begin
          v[1] <= req_ren;
          if (req_ren) d[1] <= src_rdata;
          for (int k = 2; k <= LATENCY; k++) begin
            v[k] <= v[k-1];
            if (v[k-1]) d[k] <= d[k-1];
          end
        end
      assign rdata = d[LATENCY];
      assign rvalid = v[LATENCY];
    end
  endgenerate
endmodule

// File: tb/tb_svc_rv_mem_model.sv
// tb_svc_rv_mem_model: scoreboard bench over LATENCY 0..3 instances (MAX_STALL=2)
module tb_svc_rv_mem_model;
`ifdef SVC_RV_MEM_MODEL_STALL_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ren [4];
  logic [31:0] addr [4];
  logic [31:0] srd [4];
  logic        sreq [4];
  logic [4:0]  idx [4];
  logic        stl [4];
  logic [31:0] rd [4];
  logic        rv [4];
  logic [2:0]  cnt [4];
  logic [31:0] q [4][$];
  int n_vec = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  for (genvar i = 0; i < 4; i++) begin : g_dut
    svc_rv_mem_model #(.LATENCY(i), .MAX_STALL(2)) u_dut (
      .clock(clock), .reset(reset), .req_ren(ren[i]), .req_raddr(addr[i]),
      .src_idx(idx[i]), .src_rdata(srd[i]), .stall_req(sreq[i]), .stall(stl[i]),
      .rdata(rd[i]), .rvalid(rv[i]), .stall_cnt(cnt[i]));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // a result is consumed on an unstalled cycle with rvalid high
  always @(negedge clock)
    if (!reset)
      for (int k = 0; k < 4; k++)
        if (rv[k] && !stl[k]) begin
          if (q[k].size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_rdata_L%0d: got %h expected none", k, rd[k]);
          end else chk($sformatf("rdata_L%0d", k), rd[k], q[k].pop_front());
        end

  initial begin
    for (int k = 0; k < 4; k++) begin
      ren[k] = 0; addr[k] = 0; srd[k] = 0; sreq[k] = 0;
    end
    reset = 1;
    step;
    step;
    reset = 0;
    chk("rst_rdata_L1", rd[1], 32'h13);
    chk("rst_rvalid_L1", rv[1], 0);
    chk("rst_stall_L1", stl[1], 0);
    chk("rst_cnt_L1", cnt[1], 0);
    chk("rst_rdata_L0", rd[0], 0);
    chk("rst_rdata_L3", rd[3], 32'h13);
    ren[1] = 1; addr[1] = 32'h8; srd[1] = 32'hDEADBEEF; q[1].push_back(32'hDEADBEEF);
    #1;
    chk("src_idx_0x8", idx[1], 2);
    step;
    ren[1] = 0; srd[1] = 0; addr[1] = 32'h80;
    #1;
    chk("l1_rdata", rd[1], 32'hDEADBEEF);
    chk("l1_rvalid", rv[1], 1);
    chk("src_idx_wrap", idx[1], 0);
    addr[1] = 32'h7C;
    #1;
    chk("src_idx_top", idx[1], 31);
    step;
    chk("l1_rdata_hold", rd[1], 32'hDEADBEEF);
    chk("l1_rvalid_idle", rv[1], 0);
    ren[0] = 1; srd[0] = 32'hA5A55A5A; q[0].push_back(32'hA5A55A5A);
    #1;
    chk("l0_rdata", rd[0], 32'hA5A55A5A);
    chk("l0_rvalid", rv[0], 1);
    step;
    ren[0] = 0;
    #1;
    chk("l0_rdata_idle", rd[0], 0);
    ren[3] = 1; srd[3] = 32'h11; q[3].push_back(32'h11);
    step;
    srd[3] = 32'h22; q[3].push_back(32'h22);
    step;
    chk("l3_rvalid_early", rv[3], 0);
    srd[3] = 32'h33; q[3].push_back(32'h33);
    step;
    ren[3] = 0; srd[3] = 0;
    for (int i = 0; i < 3; i++) begin
      chk("l3_rvalid_burst", rv[3], 1);
      step;
    end
    chk("l3_rvalid_after", rv[3], 0);
    sreq[2] = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_no_pending", stl[2], 0);
      step;
    end
    sreq[2] = 0;
    ren[2] = 1; srd[2] = 32'h77; q[2].push_back(32'h77);
    step;
    ren[2] = 0; srd[2] = 0; sreq[2] = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_bounded", stl[2], EN && i < 2);
      chk("stall_cnt", cnt[2], (EN && i < 3) ? i : 0);
      if (i < (EN ? 3 : 1)) chk("stall_rdata_hold", rd[2], 32'h13);
      step;
    end
    sreq[2] = 0;
    step;
    step;
    ren[2] = 1; srd[2] = 32'h55;
    step;
    ren[2] = 0; srd[2] = 0; sreq[2] = 1; reset = 1;
    #1;
    chk("stall_before_reset", stl[2], EN);
    step;
    reset = 0;
    #1;
    chk("rst_mid_rvalid", rv[2], 0);
    chk("rst_mid_stall", stl[2], 0);
    chk("rst_mid_rdata", rd[2], 32'h13);
    chk("rst_mid_cnt", cnt[2], 0);
    for (int i = 0; i < 4; i++) begin
      step;
      chk("rst_mid_no_55", rv[2], 0);
    end
    sreq[2] = 0;
    repeat (8) step;
    for (int k = 0; k < 4; k++) chk($sformatf("drain_L%0d", k), q[k].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
